// File: rtl/spi_cmd_sequencer_if.sv
// Command/response handshake and spi_master_core request bus of the command sequencer.
// The slave modport is the sequencer's view; master is the environment driving commands,
// consuming responses and acting as the SPI core.
interface spi_cmd_sequencer_if #(
    parameter int CHANNEL   = 8,
    parameter int CHAN_W    = 3,
    parameter int REG_WIDTH = 16
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CHAN_W-1:0]    cmd_chan;
    logic                 cmd_rd;
    logic [REG_WIDTH-1:0] cmd_data;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [REG_WIDTH-1:0] rsp_data;
    logic [CHAN_W-1:0]    rsp_chan;
    logic                 rsp_err;

    logic [CHANNEL-1:0]   spi_wr_channel;
    logic                 spi_wr_valid;
    logic                 spi_wr_ready;
    logic [REG_WIDTH-1:0] spi_data_in;
    logic                 spi_rd_ack;
    logic [REG_WIDTH-1:0] spi_data_out;

    modport slave (
        input  cmd_valid, cmd_chan, cmd_rd, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_chan, rsp_err,
        input  rsp_ready,
        output spi_wr_channel, spi_wr_valid, spi_data_in,
        input  spi_wr_ready, spi_rd_ack, spi_data_out
    );

    modport master (
        output cmd_valid, cmd_chan, cmd_rd, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_chan, rsp_err,
        output rsp_ready,
        input  spi_wr_channel, spi_wr_valid, spi_data_in,
        output spi_wr_ready, spi_rd_ack, spi_data_out
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: FIFO-buffered commands issued one at a time to spi_master_core,
// with optional read response, CS-high gap between transfers and a response timeout.
module spi_cmd_sequencer #(
    parameter int CHANNEL     = 8,
    parameter int CHAN_W      = 3,
    parameter int REG_WIDTH   = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    spi_cmd_sequencer_if.slave            bus,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_sticky,
    input  logic                          err_clr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = CHAN_W + 1 + REG_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [31:0]   CHANNEL_U  = 32'(CHANNEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ,
        S_WAIT,
        S_RSP,
        S_GAP
    } state_t;

    // ---------------- command FIFO ----------------
    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]  count_q;
    logic           push, pop;
    logic [EW-1:0]  head;
    logic [CHAN_W-1:0]    head_chan;
    logic                 head_rd;
    logic [REG_WIDTH-1:0] head_data;
    logic                 head_legal;

    state_t state_q;

    assign bus.cmd_ready = (count_q != FULL_LEVEL);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state_q == S_LOAD);

    assign head       = mem_q[rd_ptr_q];
    assign head_chan  = head[EW-1 -: CHAN_W];
    assign head_rd    = head[REG_WIDTH];
    assign head_data  = head[REG_WIDTH-1:0];
    assign head_legal = (32'(head_chan) < CHANNEL_U);

    // Storage array: written on accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.cmd_chan, bus.cmd_rd, bus.cmd_data};
        end
    end

    // Pointers and occupancy; power-of-2 depth lets pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ---------------- sequencing FSM ----------------
    logic [CHAN_W-1:0]    chan_q;
    logic                 rd_q;
    logic [CHANNEL-1:0]   wr_channel_q;
    logic [REG_WIDTH-1:0] data_in_q;
    logic                 wr_valid_q;
    logic                 rsp_valid_q;
    logic [REG_WIDTH-1:0] rsp_data_q;
    logic                 rsp_err_q;
    logic [TW-1:0]        tmo_cnt_q;
    logic [GW-1:0]        gap_cnt_q;
    logic                 err_sticky_q;

    // State, hold registers and all registered outputs; a timeout overrides err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            chan_q       <= '0;
            rd_q         <= 1'b0;
            wr_channel_q <= '0;
            data_in_q    <= '0;
            wr_valid_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            tmo_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            if (err_clr) err_sticky_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) state_q <= S_LOAD;
                end

                S_LOAD: begin
                    chan_q    <= head_chan;
                    rd_q      <= head_rd;
                    data_in_q <= head_data;
                    if (head_legal) begin
                        wr_channel_q <= CHANNEL'(1) << head_chan;
                        wr_valid_q   <= 1'b1;
                        state_q      <= S_REQ;
                    end else begin
                        wr_channel_q <= '0;
                        if (head_rd) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_err_q   <= 1'b1;
                            state_q     <= S_RSP;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end
                end

                S_REQ: begin
                    if (bus.spi_wr_ready) begin
                        wr_valid_q <= 1'b0;
                        tmo_cnt_q  <= '0;
                        state_q    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.spi_rd_ack) begin
                        rsp_data_q <= bus.spi_data_out;
                        rsp_err_q  <= 1'b0;
                        if (rd_q) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RSP;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        err_sticky_q <= 1'b1;
                        rsp_data_q   <= '0;
                        rsp_err_q    <= 1'b1;
                        if (rd_q) begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RSP;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end

                S_RSP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        gap_cnt_q   <= '0;
                        state_q     <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) state_q <= S_IDLE;
                    else                       gap_cnt_q <= gap_cnt_q + 1'b1;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.spi_wr_channel = wr_channel_q;
    assign bus.spi_wr_valid   = wr_valid_q;
    assign bus.spi_data_in    = data_in_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_data       = rsp_data_q;
    assign bus.rsp_chan       = chan_q;
    assign bus.rsp_err        = rsp_err_q;

    assign busy       = (state_q != S_IDLE) || (count_q != '0);
    assign fifo_level = count_q;
    assign err_sticky = err_sticky_q;
endmodule
